uart_tx_prescaler: RTL and testbench
====================================

UART_TX_PRESCALER -- requirements
Module: uart_tx_prescaler

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have port clock  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port tx_data  input  8  byte to transmit; sampled only on accept.
REQ-005 SHALL have port tx_start  input  1  transmit request; level-sampled each cycle.
REQ-006 SHALL have port baudrate_sel  input  2  rate: 00=9600, 01=19200, 10=57600, 11=115200.
REQ-007 SHALL have port tx_serial  output  1  UART line; idle high.
REQ-008 SHALL have port tx_busy  output  1  high while a frame is in progress.
REQ-009 SHALL have port tx_done  output  1  one-cycle pulse at frame end.

Function
REQ-010 SHALL send frames of 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1); no parity.
REQ-011 SHALL set bit period DIV = CLK_FREQ/baud, truncated; at default clock: 5208, 2604, 868, 434.
REQ-012 SHALL size the prescaler counter for the largest DIV (13 bits at default).
REQ-013 SHALL implement states IDLE, START, DATA, STOP.
REQ-014 SHALL accept a request when tx_start=1 in IDLE and reset=0; tx_data and baudrate_sel latched in that same cycle.
REQ-015 SHALL, for accept at cycle N, drive tx_serial=0 and tx_busy=1 from cycle N+1.
REQ-016 SHALL hold each bit exactly DIV clock cycles; whole frame = 10*DIV cycles, N+1 through N+10*DIV.
REQ-017 SHALL use a 3-bit index in DATA; move to STOP after bit 7's period.
REQ-018 SHALL assert tx_done for exactly the last cycle of the stop bit (N+10*DIV).
REQ-019 SHALL deassert tx_busy at N+10*DIV+1 and return to IDLE.
REQ-020 SHALL ignore tx_start while tx_busy=1; no queuing, no effect on the frame in flight.
REQ-021 SHALL accept a new request at earliest N+10*DIV+1; minimum one-cycle idle-high gap between frames.
REQ-022 SHALL ignore changes of tx_data or baudrate_sel during a frame.
REQ-023 SHALL restart the prescaler at 0 on every bit boundary; no drift accumulation.
REQ-024 SHALL register tx_serial, tx_busy and tx_done; no combinational path from inputs to outputs.

Reset
REQ-025 SHALL, with reset=1 at a clock edge, force state IDLE, tx_serial=1, tx_busy=0, tx_done=0, prescaler=0, bit index=0, latched data=8'h00, latched rate=00.
REQ-026 SHALL, on reset mid-frame, abort the frame; line high the next cycle; no tx_done pulse.
REQ-027 SHALL give reset priority over a simultaneous tx_start; the request is lost.

Structure
REQ-028 SHALL take DIV constants, baudrate_sel encodings and state encodings from shared package uart_pkg, reused by the receiver.
REQ-029 SHALL contain one sub-module uart_baud_gen: takes clock, reset, a clear input and the latched rate; emits one-cycle bit_tick every DIV cycles.
REQ-030 SHALL keep FSM and shift register in uart_tx_prescaler; RTL total 120-400 lines.

Verification
REQ-031 SHALL check: baudrate_sel=11, tx_data=8'h55, tx_start one cycle at N -> line 0,1,0,1,0,1,0,1,0,1, each 434 cycles; tx_done only at N+4340; tx_busy low at N+4341.
REQ-032 SHALL check: baudrate_sel=00, tx_data=8'hA3 -> start, then bits 1,1,0,0,0,1,0,1, then stop; each 5208 cycles; frame 52080 cycles.
REQ-033 SHALL check: tx_start held high continuously with 8'hFF at sel=10 -> consecutive frames 8681 cycles apart; exactly one idle-high cycle between frames.
REQ-034 SHALL check: tx_data changed to 8'h00 and baudrate_sel to 00 mid-frame (sel=11, data 8'h0F) -> frame still carries 8'h0F at 434 cycles/bit.
REQ-035 SHALL check: reset at cycle 2000 of a sel=11 frame -> tx_serial=1 and tx_busy=0 next cycle; no tx_done; new frame accepted after reset releases.
REQ-036 SHALL check: tx_start and reset both high in IDLE -> no frame; line stays high.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud-rate select encoding and
// bit-period divisors. Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  typedef enum logic [1:0] {
    BAUD_9600   = 2'b00,
    BAUD_19200  = 2'b01,
    BAUD_57600  = 2'b10,
    BAUD_115200 = 2'b11
  } baud_sel_e;

  localparam int unsigned DEFAULT_CLK_FREQ = 50_000_000;

  function automatic int unsigned baud_rate(input baud_sel_e sel);
    case (sel)
      BAUD_9600:   return 9600;
      BAUD_19200:  return 19200;
      BAUD_57600:  return 57600;
      BAUD_115200: return 115200;
      default:     return 9600;
    endcase
  endfunction

  // Clock cycles per bit, truncated.
  function automatic int unsigned bit_div(input int unsigned clk_freq, input baud_sel_e sel);
    return clk_freq / baud_rate(sel);
  endfunction

  // The slowest rate has the largest divisor and sets the counter width.
  function automatic int cnt_width(input int unsigned clk_freq);
    int w;
    w = $clog2(bit_div(clk_freq, BAUD_9600));
    return (w < 1) ? 1 : w;
  endfunction

  localparam int unsigned DIV_9600   = bit_div(DEFAULT_CLK_FREQ, BAUD_9600);
  localparam int unsigned DIV_19200  = bit_div(DEFAULT_CLK_FREQ, BAUD_19200);
  localparam int unsigned DIV_57600  = bit_div(DEFAULT_CLK_FREQ, BAUD_57600);
  localparam int unsigned DIV_115200 = bit_div(DEFAULT_CLK_FREQ, BAUD_115200);

endpackage

// File: rtl/uart_tx_prescaler_if.sv
// Transmit-side handshake and line signals between a byte source and the
// UART transmitter.
interface uart_tx_prescaler_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [1:0] baudrate_sel;
  logic       tx_serial;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_data, tx_start, baudrate_sel,
    input  tx_serial, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_start, baudrate_sel,
    output tx_serial, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period prescaler: counts clock cycles and flags the last cycle of each
// bit period (bit_tick) and the cycle before it (tick_early).
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEFAULT_CLK_FREQ
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      clear,
  input  baud_sel_e rate,
  output logic      bit_tick,
  output logic      tick_early
);

  localparam int CNT_W = cnt_width(CLK_FREQ);

  localparam logic [CNT_W-1:0] LAST_9600   = CNT_W'(bit_div(CLK_FREQ, BAUD_9600) - 1);
  localparam logic [CNT_W-1:0] LAST_19200  = CNT_W'(bit_div(CLK_FREQ, BAUD_19200) - 1);
  localparam logic [CNT_W-1:0] LAST_57600  = CNT_W'(bit_div(CLK_FREQ, BAUD_57600) - 1);
  localparam logic [CNT_W-1:0] LAST_115200 = CNT_W'(bit_div(CLK_FREQ, BAUD_115200) - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] last_cnt;

  always_comb begin
    last_cnt = LAST_9600;
    case (rate)
      BAUD_9600:   last_cnt = LAST_9600;
      BAUD_19200:  last_cnt = LAST_19200;
      BAUD_57600:  last_cnt = LAST_57600;
      BAUD_115200: last_cnt = LAST_115200;
      default:     last_cnt = LAST_9600;
    endcase
  end

  // Wrapping to zero on every period keeps bit boundaries drift-free.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (cnt_q == last_cnt) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bit_tick   = (cnt_q == last_cnt);
  assign tick_early = (cnt_q == (last_cnt - 1'b1));

endmodule

// File: rtl/uart_tx_prescaler.sv
// UART transmitter, 8N1, LSB first, with selectable baud rate.
//   state    | meaning
//   ST_IDLE  | line high, waiting for tx_start
//   ST_START | driving start bit (0)
//   ST_DATA  | driving data bit idx_q
//   ST_STOP  | driving stop bit (1); tx_done in its last cycle
module uart_tx_prescaler
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEFAULT_CLK_FREQ
) (
  input  logic                 clock,
  input  logic                 reset,
  uart_tx_prescaler_if.slave   tx
);

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  idx_q, idx_d;
  baud_sel_e   rate_q, rate_d;
  logic        serial_q, serial_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        bit_tick;
  logic        tick_early;
  logic        baud_clear;

  // Holding the prescaler cleared in IDLE aligns the first bit to the accept edge.
  assign baud_clear = (state_q == ST_IDLE);

  uart_baud_gen #(
    .CLK_FREQ (CLK_FREQ)
  ) u_baud_gen (
    .clock      (clock),
    .reset      (reset),
    .clear      (baud_clear),
    .rate       (rate_q),
    .bit_tick   (bit_tick),
    .tick_early (tick_early)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shift_q  <= 8'h00;
      idx_q    <= 3'd0;
      rate_q   <= BAUD_9600;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      rate_q   <= rate_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    rate_d   = rate_q;
    serial_d = serial_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx.tx_start) begin
          state_d  = ST_START;
          shift_d  = tx.tx_data;
          rate_d   = baud_sel_e'(tx.baudrate_sel);
          idx_d    = 3'd0;
          serial_d = 1'b0;
          busy_d   = 1'b1;
        end
      end

      ST_START: begin
        if (bit_tick) begin
          state_d  = ST_DATA;
          serial_d = shift_q[0];
          shift_d  = {1'b0, shift_q[7:1]};
        end
      end

      ST_DATA: begin
        if (bit_tick) begin
          if (idx_q == 3'd7) begin
            state_d  = ST_STOP;
            serial_d = 1'b1;
          end else begin
            serial_d = shift_q[0];
            shift_d  = {1'b0, shift_q[7:1]};
            idx_d    = idx_q + 1'b1;
          end
        end
      end

      ST_STOP: begin
        // Registered, so it is raised one cycle ahead to land on the final stop cycle.
        done_d = tick_early;
        if (bit_tick) begin
          state_d  = ST_IDLE;
          serial_d = 1'b1;
          busy_d   = 1'b0;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        serial_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  assign tx.tx_serial = serial_q;
  assign tx.tx_busy   = busy_q;
  assign tx.tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_prescaler.sv
// Directed bench for uart_tx_prescaler at the default 50 MHz clock.
module tb_uart_tx_prescaler;

  logic clock = 1'b0;
  logic reset = 1'b1;

  uart_tx_prescaler_if tx_if ();

  uart_tx_prescaler #(
    .CLK_FREQ (50_000_000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .tx    (tx_if)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Observe 1 time unit after the rising edge; values seen are those of the next cycle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_idle(input string tag);
    check($sformatf("%s serial", tag), {31'd0, tx_if.tx_serial}, 32'd1);
    check($sformatf("%s busy", tag),   {31'd0, tx_if.tx_busy},   32'd0);
    check($sformatf("%s done", tag),   {31'd0, tx_if.tx_done},   32'd0);
  endtask

  // Drive a request; returns after the accept edge, observing cycle N+1.
  task automatic accept(input logic [7:0] data, input logic [1:0] sel, input bit hold);
    tx_if.tx_data      = data;
    tx_if.baudrate_sel = sel;
    tx_if.tx_start     = 1'b1;
    tick();
    if (!hold) tx_if.tx_start = 1'b0;
  endtask

  // Entered at cycle N+1, leaves at cycle N+10*div+1.
  task automatic run_frame(input string tag, input logic [7:0] data, input int div, input bit mid_change);
    logic [9:0] bits;
    int         done_seen;
    bits      = {1'b1, data, 1'b0};
    done_seen = 0;
    for (int b = 0; b < 10; b++) begin
      int bad;
      bad = 0;
      for (int c = 0; c < div; c++) begin
        if (tx_if.tx_serial !== bits[b] || tx_if.tx_busy !== 1'b1) bad++;
        if (tx_if.tx_done === 1'b1) begin
          done_seen++;
          if (!(b == 9 && c == div - 1)) bad++;
        end else if (tx_if.tx_done !== 1'b0) begin
          bad++;
        end else if (b == 9 && c == div - 1) begin
          bad++;
        end
        if (mid_change && b == 3 && c == 0) begin
          tx_if.tx_data      = 8'h00;
          tx_if.baudrate_sel = 2'b00;
        end
        tick();
      end
      check($sformatf("%s bit%0d bad cycles", tag, b), bad, 32'd0);
    end
    check($sformatf("%s done pulses", tag), done_seen, 32'd1);
    check_idle($sformatf("%s after frame", tag));
  endtask

  initial begin
    int bad;
    int done_seen;

    tx_if.tx_data      = 8'h00;
    tx_if.tx_start     = 1'b0;
    tx_if.baudrate_sel = 2'b00;

    // Reset state
    reset = 1'b1;
    tick(); tick(); tick();
    check_idle("reset");
    reset = 1'b0;
    tick();
    check_idle("post reset idle");

    // 8'h55 at 115200: 434 cycles/bit, done at N+4340, busy low at N+4341
    accept(8'h55, 2'b11, 1'b0);
    run_frame("0x55@115200", 8'h55, 434, 1'b0);
    tick();

    // 8'hA3 at 9600: 5208 cycles/bit
    accept(8'hA3, 2'b00, 1'b0);
    run_frame("0xA3@9600", 8'hA3, 5208, 1'b0);
    tick();

    // tx_start held: frames 8681 cycles apart with one idle-high cycle between
    accept(8'hFF, 2'b10, 1'b1);
    run_frame("b2b frame1", 8'hFF, 868, 1'b0);
    tick();
    tx_if.tx_start = 1'b0;
    run_frame("b2b frame2", 8'hFF, 868, 1'b0);
    tick();
    check_idle("b2b no third frame");

    // Data and rate changed mid-frame must not disturb the frame in flight
    accept(8'h0F, 2'b11, 1'b0);
    run_frame("mid change", 8'h0F, 434, 1'b1);
    tick();

    // Reset in the middle of a frame
    accept(8'hC3, 2'b11, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 1999; i++) begin
      if (tx_if.tx_done === 1'b1) done_seen++;
      tick();
    end
    check("abort pre serial", {31'd0, tx_if.tx_serial}, 32'd0);
    check("abort pre busy",   {31'd0, tx_if.tx_busy},   32'd1);
    reset = 1'b1;
    tick();
    check_idle("abort reset");
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      if (tx_if.tx_done === 1'b1) done_seen++;
      if (tx_if.tx_serial !== 1'b1 || tx_if.tx_busy !== 1'b0) bad++;
      tick();
    end
    check("abort no done", done_seen, 32'd0);
    check("abort idle cycles bad", bad, 32'd0);
    accept(8'h3C, 2'b11, 1'b0);
    run_frame("after abort", 8'h3C, 434, 1'b0);
    tick();

    // Reset and tx_start together in IDLE: request lost
    tx_if.tx_data      = 8'hAA;
    tx_if.baudrate_sel = 2'b11;
    tx_if.tx_start     = 1'b1;
    reset              = 1'b1;
    tick();
    tx_if.tx_start = 1'b0;
    reset          = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (tx_if.tx_serial !== 1'b1 || tx_if.tx_busy !== 1'b0 || tx_if.tx_done !== 1'b0) bad++;
      tick();
    end
    check("reset vs start bad cycles", bad, 32'd0);
    check_idle("reset vs start");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
